// File: rtl/decode_stage.sv
// Instruction decode stage: registers a decoded control/operand bundle with a
// valid/ready handshake, a RUN/HALT controller and a load-use hazard bubble.
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int SIGN_EXT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [4:0]        shamt,
  output logic [DATA_W-1:0] im_data,
  output logic [4:0]        alu_op,
  output logic [1:0]        jump_sel,
  output logic              wb_sel,
  output logic              alu_b_sel,
  output logic              reg_we_w,
  output logic              reg_we_b,
  output logic              mem_we_w,
  output logic              mem_we_b,
  output logic              mem_re_w,
  output logic              mem_re_b,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] im_data;
    logic [4:0]        alu_op;
    logic [1:0]        jump_sel;
    logic              wb_sel;
    logic              alu_b_sel;
    logic              reg_we_w;
    logic              reg_we_b;
    logic              mem_we_w;
    logic              mem_we_b;
    logic              mem_re_w;
    logic              mem_re_b;
  } bundle_t;

  state_t            state_q, state_d;
  bundle_t           dec, bundle_q;
  logic              out_valid_q, illegal_q;
  logic [CNT_W-1:0]  stall_q;
  logic [5:0]        op;
  logic [DATA_W-1:0] ext;
  logic              op_halt, op_illegal, op_legal;
  logic              reads_rs, reads_rt;
  logic              hazard, accept, run;

  assign op         = instr[31:26];
  assign op_halt    = (op == 6'd0);
  assign op_illegal = op[5];
  assign op_legal   = ~op_halt & ~op_illegal;

  if (DATA_W > 16) begin : g_ext
    assign ext = {{(DATA_W-16){(SIGN_EXT != 0) ? instr[15] : 1'b0}}, instr[15:0]};
  end else begin : g_ext16
    assign ext = instr[15:0];
  end

  // Opcode groups: 1-15 R-type, 16-23 immediate ALU, 24-27 memory, 28-31 jump/branch.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    dec      = '0;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    if (op_legal) begin
      if (!op[4]) begin
        dec.rd       = instr[21 +: REG_AW];
        dec.rs       = instr[16 +: REG_AW];
        dec.rt       = instr[11 +: REG_AW];
        dec.shamt    = instr[10:6];
        dec.alu_op   = {1'b0, op[3:0]};
        dec.wb_sel   = 1'b1;
        dec.reg_we_w = 1'b1;
        reads_rs     = 1'b1;
        reads_rt     = 1'b1;
      end else if (!op[3]) begin
        dec.rd        = instr[21 +: REG_AW];
        dec.rs        = instr[16 +: REG_AW];
        dec.im_data   = ext;
        dec.alu_b_sel = 1'b1;
        dec.wb_sel    = 1'b1;
        dec.reg_we_w  = 1'b1;
        reads_rs      = 1'b1;
        unique case (op[2:0])
          3'd2:    dec.alu_op = 5'b00001;
          3'd3:    dec.alu_op = 5'b00010;
          3'd4:    dec.alu_op = 5'b00011;
          3'd5:    dec.alu_op = 5'b00100;
          3'd6:    dec.alu_op = 5'b01001;
          3'd7:    dec.alu_op = 5'b01010;
          default: dec.alu_op = 5'b00000;
        endcase
      end else if (!op[2]) begin
        dec.rs        = instr[16 +: REG_AW];
        dec.rt        = instr[21 +: REG_AW];
        dec.rd        = instr[21 +: REG_AW];
        dec.im_data   = ext;
        dec.alu_op    = 5'b00001;
        dec.alu_b_sel = 1'b1;
        reads_rs      = 1'b1;
        reads_rt      = op[0];  // stores read the data register
        unique case (op[1:0])
          2'd0: begin dec.mem_re_w = 1'b1; dec.reg_we_w = 1'b1; end
          2'd1: dec.mem_we_w = 1'b1;
          2'd2: begin dec.mem_re_b = 1'b1; dec.reg_we_b = 1'b1; end
          2'd3: dec.mem_we_b = 1'b1;
        endcase
      end else begin
        dec.rs      = instr[21 +: REG_AW];
        dec.rt      = instr[16 +: REG_AW];
        dec.im_data = ext;
        reads_rs    = (op[1:0] != 2'd0);
        reads_rt    = (op[1:0] != 2'd0);
        unique case (op[1:0])
          2'd0: begin dec.jump_sel = 2'd3; dec.alu_op = 5'b00000; end
          2'd1: begin dec.jump_sel = 2'd2; dec.alu_op = 5'b00000; end
          2'd2: begin dec.jump_sel = 2'd1; dec.alu_op = 5'b10000; end
          2'd3: begin dec.jump_sel = 2'd1; dec.alu_op = 5'b01111; end
        endcase
      end
    end
  end

  // Load-use: the pending load writes a register the incoming instruction reads.
  assign hazard = out_valid_q & (bundle_q.mem_re_w | bundle_q.mem_re_b) &
                  (bundle_q.rd != '0) & in_valid &
                  ((reads_rs & (dec.rs == bundle_q.rd)) |
                   (reads_rt & (dec.rt == bundle_q.rd)));

  assign in_ready = run & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (accept & op_halt) state_d = HALT;
      HALT: if (resume)           state_d = RUN;
    endcase
  end

  always_comb begin
    run    = (state_q == RUN);
    halted = (state_q == HALT);
  end

  // NOTE: the bundle register is reset along with out_valid so reset clears every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (accept) begin
        illegal_q   <= op_illegal;
        out_valid_q <= op_legal;
        if (op_legal) bundle_q <= dec;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (hazard && out_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_q;
  assign rs        = bundle_q.rs;
  assign rt        = bundle_q.rt;
  assign rd        = bundle_q.rd;
  assign shamt     = bundle_q.shamt;
  assign im_data   = bundle_q.im_data;
  assign alu_op    = bundle_q.alu_op;
  assign jump_sel  = bundle_q.jump_sel;
  assign wb_sel    = bundle_q.wb_sel;
  assign alu_b_sel = bundle_q.alu_b_sel;
  assign reg_we_w  = bundle_q.reg_we_w;
  assign reg_we_b  = bundle_q.reg_we_b;
  assign mem_we_w  = bundle_q.mem_we_w;
  assign mem_we_b  = bundle_q.mem_we_b;
  assign mem_re_w  = bundle_q.mem_re_w;
  assign mem_re_b  = bundle_q.mem_re_b;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of expected bundles plus directed checks
// for hazard bubbles, halt/resume, backpressure, illegal opcodes and reset.
module tb_decode_stage;

  logic        clk, rst, in_valid, resume, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, wb_sel, alu_b_sel, reg_we_w, reg_we_b;
  logic        mem_we_w, mem_we_b, mem_re_w, mem_re_b, halted, illegal;
  logic [4:0]  rs, rt, rd, shamt, alu_op;
  logic [1:0]  jump_sel;
  logic [31:0] im_data;
  logic [15:0] stall_cnt;

  logic        in_ready_z, out_valid_z, wb_sel_z, alu_b_sel_z, reg_we_w_z, reg_we_b_z;
  logic        mem_we_w_z, mem_we_b_z, mem_re_w_z, mem_re_b_z, halted_z, illegal_z;
  logic [4:0]  rs_z, rt_z, rd_z, shamt_z, alu_op_z;
  logic [1:0]  jump_sel_z;
  logic [31:0] im_data_z;
  logic [15:0] stall_cnt_z;

  decode_stage #(.DATA_W(32), .REG_AW(5), .SIGN_EXT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .im_data(im_data), .alu_op(alu_op),
    .jump_sel(jump_sel), .wb_sel(wb_sel), .alu_b_sel(alu_b_sel),
    .reg_we_w(reg_we_w), .reg_we_b(reg_we_b), .mem_we_w(mem_we_w), .mem_we_b(mem_we_b),
    .mem_re_w(mem_re_w), .mem_re_b(mem_re_b), .halted(halted), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  decode_stage #(.DATA_W(32), .REG_AW(5), .SIGN_EXT(0), .CNT_W(16)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z), .instr(instr),
    .resume(resume), .out_valid(out_valid_z), .out_ready(out_ready),
    .rs(rs_z), .rt(rt_z), .rd(rd_z), .shamt(shamt_z), .im_data(im_data_z), .alu_op(alu_op_z),
    .jump_sel(jump_sel_z), .wb_sel(wb_sel_z), .alu_b_sel(alu_b_sel_z),
    .reg_we_w(reg_we_w_z), .reg_we_b(reg_we_b_z), .mem_we_w(mem_we_w_z), .mem_we_b(mem_we_b_z),
    .mem_re_w(mem_re_w_z), .mem_re_b(mem_re_b_z), .halted(halted_z), .illegal(illegal_z),
    .stall_cnt(stall_cnt_z)
  );

  logic [34:0] ctrl_act;
  assign ctrl_act = {rs, rt, rd, shamt, alu_op, jump_sel, wb_sel, alu_b_sel,
                     reg_we_w, reg_we_b, mem_we_w, mem_we_b, mem_re_w, mem_re_b};

  typedef struct {
    logic [34:0] ctrl;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_force = 1'b1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decode written from the opcode tables.
  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    logic [5:0]  op;
    logic [4:0]  a25, a20, a15, sh, alu, s1, s2, d;
    logic [1:0]  js;
    logic        wb, ab, rww, rwb, mww, mwb, mrw, mrb;
    logic [31:0] is, iz;
    op = w[31:26]; a25 = w[25:21]; a20 = w[20:16]; a15 = w[15:11];
    s1 = 0; s2 = 0; d = 0; sh = 0; alu = 0; js = 0;
    wb = 0; ab = 0; rww = 0; rwb = 0; mww = 0; mwb = 0; mrw = 0; mrb = 0;
    is = {{16{w[15]}}, w[15:0]};
    iz = {16'h0000, w[15:0]};
    e.imm_s = 32'h0; e.imm_z = 32'h0;
    if (op >= 6'd1 && op <= 6'd15) begin
      d = a25; s1 = a20; s2 = a15; sh = w[10:6]; alu = {1'b0, op[3:0]}; wb = 1; rww = 1;
    end else if (op >= 6'd16 && op <= 6'd23) begin
      d = a25; s1 = a20; ab = 1; wb = 1; rww = 1; e.imm_s = is; e.imm_z = iz;
      case (op)
        6'd18:   alu = 5'b00001;
        6'd19:   alu = 5'b00010;
        6'd20:   alu = 5'b00011;
        6'd21:   alu = 5'b00100;
        6'd22:   alu = 5'b01001;
        6'd23:   alu = 5'b01010;
        default: alu = 5'b00000;
      endcase
    end else if (op >= 6'd24 && op <= 6'd27) begin
      s1 = a20; s2 = a25; d = a25; alu = 5'b00001; ab = 1; e.imm_s = is; e.imm_z = iz;
      case (op)
        6'd24:   begin mrw = 1; rww = 1; end
        6'd25:   mww = 1;
        6'd26:   begin mrb = 1; rwb = 1; end
        default: mwb = 1;
      endcase
    end else if (op >= 6'd28 && op <= 6'd31) begin
      s1 = a25; s2 = a20; e.imm_s = is; e.imm_z = iz;
      js  = (op == 6'd28) ? 2'd3 : (op == 6'd29) ? 2'd2 : 2'd1;
      alu = (op == 6'd30) ? 5'b10000 : (op == 6'd31) ? 5'b01111 : 5'b00000;
    end
    e.ctrl = {s1, s2, d, sh, alu, js, wb, ab, rww, rwb, mww, mwb, mrw, mrb};
    return e;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Scoreboard: push on accepted legal instructions, pop on consumed bundles.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_bundle", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_ctrl", 64'(ctrl_act), 64'(e.ctrl));
          check("sb_imm_sext", 64'(im_data), 64'(e.imm_s));
          check("sb_imm_zext", 64'(im_data_z), 64'(e.imm_z));
        end
      end
      if (in_valid && in_ready && instr[31:26] != 6'd0 && !instr[31]) sb.push_back(model(instr));
    end
  end

  task automatic send(input logic [31:0] w, output int waits);
    in_valid = 1'b1;
    instr    = w;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 40);
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int          w;
    logic [31:0] r;
    logic [5:0]  op;
    exp_t        ea;
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; resume = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_ctrl", 64'(ctrl_act), 64'd0);
    check("rst_im_data", 64'(im_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic R-type decode with one-cycle latency
    send(32'h0441_0000, w);
    check("basic_latency", 64'(out_valid), 64'd1);
    check("basic_rd", 64'(rd), 64'd2);
    check("basic_rs", 64'(rs), 64'd1);
    check("basic_alu_op", 64'(alu_op), 64'b00001);
    check("basic_reg_we_w", 64'(reg_we_w), 64'd1);

    // Immediate extension, both polarities
    send(32'h4800_FFFE, w);
    check("imm_sext", 64'(im_data), 64'hFFFF_FFFE);
    check("imm_zext", 64'(im_data_z), 64'h0000_FFFE);
    send(32'h4C00_0001, w);
    check("imm_alu_op_19", 64'(alu_op), 64'b00010);
    check("imm_alu_b_sel", 64'(alu_b_sel), 64'd1);

    // Load-use hazards: rs read, rd=0 load, rt read by a store
    send(32'h6060_0000, w);
    send(32'h0403_0000, w);
    check("haz_rs_waits", 64'(w), 64'd2);
    check("haz_rs_stall_cnt", 64'(stall_cnt), 64'd1);
    send(32'h6000_0000, w);
    send(32'h0400_0000, w);
    check("haz_rd0_waits", 64'(w), 64'd1);
    check("haz_rd0_stall_cnt", 64'(stall_cnt), 64'd1);
    send(32'h60A0_0000, w);
    send(32'h64A0_0000, w);
    check("haz_rt_waits", 64'(w), 64'd2);
    check("haz_rt_stall_cnt", 64'(stall_cnt), 64'd2);

    // Halt, hold for 10 cycles, resume
    send(32'h0000_0000, w);
    check("halt_entry", 64'(halted), 64'd1);
    in_valid = 1'b1;
    instr    = 32'h0441_0000;
    repeat (10) begin
      @(negedge clk);
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    check("resume_halted", 64'(halted), 64'd0);
    send(32'h0441_0000, w);
    check("resume_waits", 64'(w), 64'd1);

    // Backpressure: bundle held stable for 5 cycles
    repeat (2) @(posedge clk);
    rdy_force = 1'b0;
    @(posedge clk);
    #3;
    send(32'h0C85_3140, w);
    ea = model(32'h0C85_3140);
    in_valid = 1'b1;
    instr    = 32'h4045_1234;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_ctrl_stable", 64'(ctrl_act), 64'(ea.ctrl));
    end
    rdy_force = 1'b1;
    send(32'h4045_1234, w);

    // Illegal opcode is a bubble and a sticky flag until the next accept
    send(32'hFC00_0000, w);
    check("illegal_flag", 64'(illegal), 64'd1);
    check("illegal_no_bundle", 64'(out_valid), 64'd0);
    check("illegal_not_halted", 64'(halted), 64'd0);
    send(32'h0441_0000, w);
    check("illegal_cleared", 64'(illegal), 64'd0);

    // Random legal stream under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 6'($urandom_range(1, 31));
      r  = $urandom();
      send({op, r[25:0]}, w);
    end
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset while halted
    @(posedge clk);
    #1;
    send(32'h0000_0000, w);
    #2;
    rst = 1'b1;
    #1;
    check("arst_halted", 64'(halted), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("arst_ctrl", 64'(ctrl_act), 64'd0);
    check("arst_im_data", 64'(im_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h0441_0000, w);
    check("post_rst_waits", 64'(w), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
